concat_zero_ctrl: RTL and testbench

// - Sequences the concat/zero-point adder datapath for a channel-concat layer.
// - Per pixel, reads cfg_grp_a channel groups from branch-A FIFO, then cfg_grp_b groups from branch-B FIFO.
// - Drives the adder mux select and the per-branch zero point, tracks adder latency, flags valid output words.
// - Sits between the two branch FIFOs and the concat output FIFO; issues nothing while the output FIFO is almost full.

---
 rtl/concat_zero_ctrl_pkg.sv | 16 +
 rtl/cz_valid_pipe.sv | 43 ++++
 rtl/concat_zero_ctrl.sv | 173 +++++++++++++++++
 tb/tb_concat_zero_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/concat_zero_ctrl_pkg.sv
// Shared types and defaults for the concat/zero-point sequencer.
package concat_zero_ctrl_pkg;

  localparam int unsigned PIX_W_DEF  = 20;
  localparam int unsigned GRP_W_DEF  = 10;
  localparam int unsigned ZERO_W     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/cz_valid_pipe.sv
// Shift register of {valid, sel_b} tracking every issued read through the FIFO
// read latency and the adder pipeline. Stage i holds the issue from i+1 cycles ago.
module cz_valid_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic             sel_i,
  output logic [Depth-1:0] valid_o,
  output logic [Depth-1:0] sel_o
);

  logic [Depth-1:0] vld_q, vld_d;
  logic [Depth-1:0] sel_q, sel_d;

  // Shift one stage per cycle; the pipe never stalls.
  always_comb begin
    vld_d    = vld_q;
    sel_d    = sel_q;
    vld_d[0] = valid_i;
    sel_d[0] = sel_i;
    for (int i = 1; i < Depth; i++) begin
      vld_d[i] = vld_q[i-1];
      sel_d[i] = sel_q[i-1];
    end
  end

  // Synchronous clear discards every word in flight.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      sel_q <= '0;
    end else begin
      vld_q <= vld_d;
      sel_q <= sel_d;
    end
  end

  assign valid_o = vld_q;
  assign sel_o   = sel_q;

endmodule

// File: rtl/concat_zero_ctrl.sv
// Sequences branch-A / branch-B FIFO reads for a channel-concat layer and
// aligns mux select, zero point and output-valid with the datapath.
module concat_zero_ctrl
  import concat_zero_ctrl_pkg::*;
#(
  parameter int unsigned ADD_LATENCY = 1,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned GRP_W       = GRP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  cfg_pixels,
  input  logic [GRP_W-1:0]  cfg_grp_a,
  input  logic [GRP_W-1:0]  cfg_grp_b,
  input  logic [ZERO_W-1:0] cfg_zero_a,
  input  logic [ZERO_W-1:0] cfg_zero_b,
  input  logic              a_empty,
  output logic              a_rd_en,
  input  logic              b_empty,
  output logic              b_rd_en,
  input  logic              out_almost_full,
  output logic              sel_b,
  output logic [ZERO_W-1:0] zero_data_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PipeDepth = RD_LATENCY + ADD_LATENCY;
  localparam int unsigned DataTap   = RD_LATENCY - 1;

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pixels_q, pix_cnt_q, pix_cnt_d;
  logic [GRP_W-1:0]   grp_a_q, grp_b_q, grp_cnt_q, grp_cnt_d;
  logic [ZERO_W-1:0]  zero_a_q, zero_b_q;
  logic               sel_hold_q;
  logic               last_a, last_b, last_pix, accept, in_flight;
  logic               data_vld, data_sel;
  logic [PipeDepth-1:0] pipe_vld, pipe_sel;

  assign accept   = (state_q == StIdle) && start;
  assign last_a   = (grp_cnt_q == grp_a_q - GRP_W'(1));
  assign last_b   = (grp_cnt_q == grp_b_q - GRP_W'(1));
  assign last_pix = (pix_cnt_q == pixels_q - PIX_W'(1));

  // Layer configuration, captured once per accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixels_q <= '0;
      grp_a_q  <= '0;
      grp_b_q  <= '0;
      zero_a_q <= '0;
      zero_b_q <= '0;
    end else if (accept) begin
      pixels_q <= cfg_pixels;
      grp_a_q  <= cfg_grp_a;
      grp_b_q  <= cfg_grp_b;
      zero_a_q <= cfg_zero_a;
      zero_b_q <= cfg_zero_b;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grp_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grp_cnt_q <= grp_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  // Next-state, issue strobes and status; issue is gated only by FIFO flags.
  always_comb begin
    state_d   = state_q;
    grp_cnt_d = grp_cnt_q;
    pix_cnt_d = pix_cnt_q;
    a_rd_en   = 1'b0;
    b_rd_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRdA;
          grp_cnt_d = '0;
          pix_cnt_d = '0;
        end
      end
      StRdA: begin
        busy    = 1'b1;
        a_rd_en = !a_empty && !out_almost_full;
        if (a_rd_en) begin
          if (last_a) begin
            grp_cnt_d = '0;
            state_d   = StRdB;
          end else begin
            grp_cnt_d = grp_cnt_q + GRP_W'(1);
          end
        end
      end
      StRdB: begin
        busy    = 1'b1;
        b_rd_en = !b_empty && !out_almost_full;
        if (b_rd_en) begin
          if (last_b) begin
            grp_cnt_d = '0;
            if (last_pix) begin
              pix_cnt_d = '0;
              state_d   = StDrain;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
              state_d   = StRdA;
            end
          end else begin
            grp_cnt_d = grp_cnt_q + GRP_W'(1);
          end
        end
      end
      StDrain: begin
        busy = 1'b1;
        // The word in the last stage is emitted this cycle, so done follows it by one.
        if (!in_flight) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  cz_valid_pipe #(
    .Depth(PipeDepth)
  ) u_valid_pipe (
    .clk_i  (clk),
    .clr_i  (rst),
    .valid_i(a_rd_en | b_rd_en),
    .sel_i  (b_rd_en),
    .valid_o(pipe_vld),
    .sel_o  (pipe_sel)
  );

  // Anything still in flight other than the word leaving the adder now.
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < int'(PipeDepth) - 1; i++) begin
      in_flight = in_flight | pipe_vld[i];
    end
  end

  assign data_vld = pipe_vld[DataTap];
  assign data_sel = pipe_sel[DataTap];

  // Remember the select of the last data word so the mux holds between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_hold_q <= 1'b0;
    end else if (data_vld) begin
      sel_hold_q <= data_sel;
    end
  end

  assign sel_b         = data_vld ? data_sel : sel_hold_q;
  assign zero_data_out = sel_b ? zero_b_q : zero_a_q;
  assign out_valid     = pipe_vld[PipeDepth-1];

endmodule

// File: tb/tb_concat_zero_ctrl.sv
// Directed bench: scoreboard of issued reads predicts data-cycle select/zero
// and out_valid timing; a second instance exercises a deeper adder.
module tb_concat_zero_ctrl;

  localparam int RD1  = 1;
  localparam int ADD1 = 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] cfg_pixels;
  logic [9:0]  cfg_grp_a, cfg_grp_b;
  logic [31:0] cfg_zero_a, cfg_zero_b;
  logic        a_empty, b_empty, oaf;
  logic        a_rd_en, b_rd_en, sel_b, out_valid, busy, done;
  logic [31:0] zero_data_out;

  logic        start2;
  logic        a_rd_en2, b_rd_en2, sel_b2, out_valid2, busy2, done2;
  logic [31:0] zero_data_out2;

  concat_zero_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_pixels     (cfg_pixels),
    .cfg_grp_a      (cfg_grp_a),
    .cfg_grp_b      (cfg_grp_b),
    .cfg_zero_a     (cfg_zero_a),
    .cfg_zero_b     (cfg_zero_b),
    .a_empty        (a_empty),
    .a_rd_en        (a_rd_en),
    .b_empty        (b_empty),
    .b_rd_en        (b_rd_en),
    .out_almost_full(oaf),
    .sel_b          (sel_b),
    .zero_data_out  (zero_data_out),
    .out_valid      (out_valid),
    .busy           (busy),
    .done           (done)
  );

  concat_zero_ctrl #(
    .ADD_LATENCY(3)
  ) dut2 (
    .clk            (clk),
    .rst            (rst),
    .start          (start2),
    .cfg_pixels     (20'd1),
    .cfg_grp_a      (10'd1),
    .cfg_grp_b      (10'd1),
    .cfg_zero_a     (32'd7),
    .cfg_zero_b     (32'hFFFF_FFF7),
    .a_empty        (1'b0),
    .a_rd_en        (a_rd_en2),
    .b_empty        (1'b0),
    .b_rd_en        (b_rd_en2),
    .out_almost_full(1'b0),
    .sel_b          (sel_b2),
    .zero_data_out  (zero_data_out2),
    .out_valid      (out_valid2),
    .busy           (busy2),
    .done           (done2)
  );

  typedef struct {
    int          due;
    logic        sel;
    logic [31:0] zero;
  } exp_t;

  exp_t        dq[$];
  int          vq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          valid_cnt = 0;
  int          done_cnt = 0;
  int          last_valid_cyc = 0;
  int          done_cyc = 0;
  string       rd_log = "";
  logic [31:0] exp_za, exp_zb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: push on issue, pop on the data cycle and on out_valid.
  always @(negedge clk) begin
    logic exp_v;
    check("rd_exclusive", {31'd0, a_rd_en & b_rd_en}, 32'd0);
    check("a_rd_gated", {31'd0, a_rd_en & (a_empty | oaf)}, 32'd0);
    check("b_rd_gated", {31'd0, b_rd_en & (b_empty | oaf)}, 32'd0);
    if (dq.size() > 0 && dq[0].due == cyc) begin
      check("sel_b_data", {31'd0, sel_b}, {31'd0, dq[0].sel});
      check("zero_data", zero_data_out, dq[0].zero);
      void'(dq.pop_front());
    end
    exp_v = (vq.size() > 0 && vq[0] == cyc);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) void'(vq.pop_front());
    if (out_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst) begin
      dq.delete();
      vq.delete();
    end else begin
      if (a_rd_en) begin
        dq.push_back('{due: cyc + RD1, sel: 1'b0, zero: exp_za});
        vq.push_back(cyc + RD1 + ADD1);
        rd_log = {rd_log, "A"};
      end
      if (b_rd_en) begin
        dq.push_back('{due: cyc + RD1, sel: 1'b1, zero: exp_zb});
        vq.push_back(cyc + RD1 + ADD1);
        rd_log = {rd_log, "B"};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int pix, input int ga, input int gb,
                             input logic [31:0] za, input logic [31:0] zb);
    cfg_pixels = 20'(pix);
    cfg_grp_a  = 10'(ga);
    cfg_grp_b  = 10'(gb);
    cfg_zero_a = za;
    cfg_zero_b = zb;
    exp_za     = za;
    exp_zb     = zb;
    rd_log     = "";
    valid_cnt  = 0;
    done_cnt   = 0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", {31'd0, done_cnt > 0}, 32'd1);
  endtask

  task automatic wait_rd(input int len, input int budget);
    int n = 0;
    while (rd_log.len() < len && n < budget) begin
      tick();
      n++;
    end
    check("rd_progress", rd_log.len(), len);
  endtask

  task automatic check_layer(input string tag);
    check({tag, "_order"}, {31'd0, rd_log == "AABAAB"}, 32'd1);
    check({tag, "_valid_cnt"}, valid_cnt, 6);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_cyc - last_valid_cyc, 1);
  endtask

  initial begin
    int saved;
    int t;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; oaf = 1'b0;
    a_empty = 1'b0; b_empty = 1'b0;
    cfg_pixels = '0; cfg_grp_a = '0; cfg_grp_b = '0; cfg_zero_a = '0; cfg_zero_b = '0;
    exp_za = '0; exp_zb = '0;
    start = 1'b1;  // start under reset must be ignored
    tick();
    tick();
    start = 1'b0;
    @(negedge clk);
    check("rst_a_rd_en", {31'd0, a_rd_en}, 32'd0);
    check("rst_b_rd_en", {31'd0, b_rd_en}, 32'd0);
    check("rst_sel_b", {31'd0, sel_b}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_zero", zero_data_out, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    // Basic layer.
    start_layer(2, 2, 1, 32'd5, 32'hFFFF_FFFD);
    wait_done(200);
    check_layer("basic");
    tick();

    // Backpressure mid RD_A.
    start_layer(2, 2, 1, 32'd11, 32'd22);
    wait_rd(1, 50);
    oaf = 1'b1;
    repeat (4) tick();
    check("bp_no_issue", rd_log.len(), 1);
    oaf = 1'b0;
    wait_done(200);
    check_layer("bp");
    tick();

    // Branch-B starvation at RD_B entry.
    b_empty = 1'b1;
    start_layer(2, 2, 1, 32'd3, 32'd4);
    wait_rd(2, 50);
    repeat (10) tick();
    check("starve_hold", rd_log.len(), 2);
    check("starve_busy", {31'd0, busy}, 32'd1);
    b_empty = 1'b0;
    wait_done(200);
    check_layer("starve");
    tick();

    // Reset mid-layer, then a clean layer.
    start_layer(2, 2, 1, 32'd9, 32'd8);
    wait_rd(3, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_a_rd_en", {31'd0, a_rd_en}, 32'd0);
    check("abort_b_rd_en", {31'd0, b_rd_en}, 32'd0);
    check("abort_sel_b", {31'd0, sel_b}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_zero", zero_data_out, 32'd0);
    saved = valid_cnt;
    repeat (10) tick();
    check("abort_no_valid", valid_cnt, saved);
    start_layer(2, 2, 1, 32'd5, 32'hFFFF_FFFD);
    wait_done(200);
    check_layer("post_rst");
    tick();

    // Second start while busy is ignored.
    start_layer(2, 2, 1, 32'd1, 32'd2);
    wait_rd(2, 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    check_layer("restart");
    repeat (10) tick();
    check("restart_single_done", done_cnt, 1);
    check("restart_idle", {31'd0, busy}, 32'd0);
    check("restart_no_reads", rd_log.len(), 6);

    // Deeper adder: out_valid 4 cycles after the read, zero aligned to data.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    t = 0;
    @(negedge clk);
    while (!a_rd_en2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lat_a_issue", {31'd0, a_rd_en2}, 32'd1);
    @(negedge clk);
    check("lat_b_issue", {31'd0, b_rd_en2}, 32'd1);
    check("lat_zero_a", zero_data_out2, 32'd7);
    check("lat_sel_a", {31'd0, sel_b2}, 32'd0);
    check("lat_v1", {31'd0, out_valid2}, 32'd0);
    @(negedge clk);
    check("lat_zero_b", zero_data_out2, 32'hFFFF_FFF7);
    check("lat_sel_b", {31'd0, sel_b2}, 32'd1);
    check("lat_v2", {31'd0, out_valid2}, 32'd0);
    @(negedge clk);
    check("lat_v3", {31'd0, out_valid2}, 32'd0);
    @(negedge clk);
    check("lat_v4", {31'd0, out_valid2}, 32'd1);
    @(negedge clk);
    check("lat_v5", {31'd0, out_valid2}, 32'd1);
    check("lat_done_early", {31'd0, done2}, 32'd0);
    @(negedge clk);
    check("lat_v6", {31'd0, out_valid2}, 32'd0);
    check("lat_done", {31'd0, done2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
